// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: shared types, window geometry defaults and constants for the program loader.
//   Provides the FSM state encoding, WR_BYTES / LOG_WR_WINDOW defaults derived from the
//   instruction-memory write geometry, and the zero-fill byte used for unused lanes.
package instr_loader_pkg;
  localparam int instr_write_width = 32;
  localparam int log_write_window_size = 2;
  localparam int WR_BYTES_DEF = instr_write_width / 8;
  localparam int LOG_WR_WINDOW_DEF = log_write_window_size;
  localparam logic [7:0] ZERO_FILL = 8'h00;
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/instr_loader_byte_packer.sv
// instr_loader_byte_packer: packs bytes little-endian into one instruction-memory write window.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : empty the window (lanes zeroed, fill count and shift cleared)
//   i_load, i_byte : store i_byte at lane o_fill_cnt
//   o_data         : window contents, lane 0 in bits [7:0], unused lanes zero
//   o_shift        : valid bytes in window minus one (0 when empty)
//   o_fill_cnt     : number of lanes filled
module instr_loader_byte_packer
  import instr_loader_pkg::*;
#(
  parameter int WR_BYTES = WR_BYTES_DEF,
  parameter int LOG_WR_WINDOW = LOG_WR_WINDOW_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  input  logic                     i_load,
  input  logic [7:0]               i_byte,
  output logic [WR_BYTES*8-1:0]    o_data,
  output logic [LOG_WR_WINDOW-1:0] o_shift,
  output logic [LOG_WR_WINDOW:0]   o_fill_cnt
);
  localparam int DW = WR_BYTES * 8;
  localparam int CW = LOG_WR_WINDOW + 1;
  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] fill_q, fill_d;
  logic [LOG_WR_WINDOW-1:0] shift_q, shift_d;
  // Lanes are zero after a clear, so OR-ing the new byte in place is enough.
  always_comb begin
    data_d = i_clr ? {WR_BYTES{ZERO_FILL}} : i_load ? data_q | (DW'(i_byte) << {fill_q, 3'b000}) : data_q;
    fill_d = i_clr ? '0 : i_load ? fill_q + CW'(1) : fill_q;
    // Registered shift tracks the lane just written, so an empty window reports 0.
    shift_d = i_clr ? '0 : i_load ? fill_q[LOG_WR_WINDOW-1:0] : shift_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q <= '0;
      fill_q <= '0;
      shift_q <= '0;
    end else begin
      data_q <= data_d;
      fill_q <= fill_d;
      shift_q <= shift_d;
    end
  end
  assign o_data = data_q;
  assign o_shift = shift_q;
  assign o_fill_cnt = fill_q;
endmodule

// File: rtl/instr_loader.sv
// instr_loader: host byte stream to instruction-memory write-window loader.
//   i_clk, i_rst_n                  : clock, asynchronous active-low reset
//   i_start                         : starts a load session from IDLE or DONE
//   i_byte_vld/i_byte/i_byte_last   : host byte stream; o_byte_rdy accepts a byte
//   o_we/o_wr_data/o_write_pointer_shift_minusone, i_wr_rdy : instruction-memory write port
//   o_load_done                     : session finished
//   o_word_count                    : windows written this session, saturating
//   o_chk_err                       : checksum mismatch, only with LOADER_CHECKSUM_EN defined
// With LOADER_CHECKSUM_EN the byte flagged last is a modular-sum checksum and is not written.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int WR_BYTES = WR_BYTES_DEF,
  parameter int LOG_WR_WINDOW = LOG_WR_WINDOW_DEF,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_byte_vld,
  input  logic [7:0]               i_byte,
  input  logic                     i_byte_last,
  output logic                     o_byte_rdy,
  output logic                     o_we,
  output logic [WR_BYTES*8-1:0]    o_wr_data,
  output logic [LOG_WR_WINDOW-1:0] o_write_pointer_shift_minusone,
  input  logic                     i_wr_rdy,
  output logic                     o_load_done,
  output logic [CNT_WIDTH-1:0]     o_word_count
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic                     o_chk_err
`endif
);
  localparam logic [LOG_WR_WINDOW:0] LAST_LANE = (LOG_WR_WINDOW + 1)'(WR_BYTES - 1);
  state_t state_q, state_d;
  logic last_q, last_d, rdy_q, rdy_d, we_q, we_d, done_q, done_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [LOG_WR_WINDOW:0] fill_cnt;
  logic accept, wr_done, clr, load;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic err_q, err_d;
`endif
  instr_loader_byte_packer #(.WR_BYTES(WR_BYTES), .LOG_WR_WINDOW(LOG_WR_WINDOW)) u_packer (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(clr), .i_load(load), .i_byte(i_byte),
    .o_data(o_wr_data), .o_shift(o_write_pointer_shift_minusone), .o_fill_cnt(fill_cnt)
  );
  always_comb begin
    accept = rdy_q & i_byte_vld;
    wr_done = we_q & i_wr_rdy;
    state_d = state_q;
    last_d = last_q;
    cnt_d = cnt_q;
    clr = 1'b0;
    load = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d = sum_q;
    err_d = err_q;
`endif
    case (state_q)
      IDLE, DONE: if (i_start) begin
        state_d = FILL;
        cnt_d = '0;
        last_d = 1'b0;
        clr = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        sum_d = '0;
        err_d = 1'b0;
`endif
      end
      FILL: if (accept) begin
        last_d = i_byte_last;
`ifdef LOADER_CHECKSUM_EN
        // The checksum byte is compared, never packed; an empty packer skips the write.
        load = ~i_byte_last;
        sum_d = i_byte_last ? sum_q : sum_q + i_byte;
        err_d = i_byte_last ? (sum_q != i_byte) : err_q;
        state_d = (i_byte_last && fill_cnt == '0) ? DONE :
                  (i_byte_last || fill_cnt == LAST_LANE) ? WRITE : FILL;
`else
        load = 1'b1;
        state_d = (i_byte_last || fill_cnt == LAST_LANE) ? WRITE : FILL;
`endif
      end
      WRITE: if (wr_done) begin
        clr = 1'b1;
        cnt_d = &cnt_q ? cnt_q : cnt_q + CNT_WIDTH'(1);
        state_d = last_q ? DONE : FILL;
      end
      default: state_d = IDLE;
    endcase
    rdy_d = state_d == FILL;
    we_d = state_d == WRITE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      last_q <= 1'b0;
      rdy_q <= 1'b0;
      we_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      rdy_q <= rdy_d;
      we_q <= we_d;
      done_q <= done_d;
      cnt_q <= cnt_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q <= sum_d;
      err_q <= err_d;
`endif
    end
  end
  assign o_byte_rdy = rdy_q;
  assign o_we = we_q;
  assign o_load_done = done_q;
  assign o_word_count = cnt_q;
`ifdef LOADER_CHECKSUM_EN
  assign o_chk_err = err_q;
`endif
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized sessions against a window-list reference model.
module tb_instr_loader;
  localparam int WRB = 4;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, vld = 1'b0, last = 1'b0, wr_rdy = 1'b0;
  logic [7:0] b = 8'h00;
  logic rdy, we, done, rdy2, we2, done2;
  logic [31:0] wd, wd2;
  logic [1:0] sh, sh2, cnt2;
  logic [15:0] cnt;
`ifdef LOADER_CHECKSUM_EN
  logic chk_err, chk_err2;
`endif
  int checks = 0, failures = 0;
  logic [7:0] prog[$];
  logic [31:0] exp_wd[$];
  int exp_sh[$];

  instr_loader dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_byte_vld(vld), .i_byte(b), .i_byte_last(last),
    .o_byte_rdy(rdy), .o_we(we), .o_wr_data(wd), .o_write_pointer_shift_minusone(sh),
    .i_wr_rdy(wr_rdy), .o_load_done(done), .o_word_count(cnt)
`ifdef LOADER_CHECKSUM_EN
    , .o_chk_err(chk_err)
`endif
  );
  instr_loader #(.CNT_WIDTH(2)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_byte_vld(vld), .i_byte(b), .i_byte_last(last),
    .o_byte_rdy(rdy2), .o_we(we2), .o_wr_data(wd2), .o_write_pointer_shift_minusone(sh2),
    .i_wr_rdy(wr_rdy), .o_load_done(done2), .o_word_count(cnt2)
`ifdef LOADER_CHECKSUM_EN
    , .o_chk_err(chk_err2)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_prog(input logic [63:0] v, input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back(v[8*i +: 8]);
  endtask

  task automatic run_session(input int vld_pct, input int rdy_pct, input int stall_cyc);
    int m, nwin, idx, cyc, stall_left;
    logic [7:0] sum;
    logic [31:0] w;
    logic exp_err;
    m = prog.size();
`ifdef LOADER_CHECKSUM_EN
    m = m - 1;
`endif
    exp_wd.delete();
    exp_sh.delete();
    sum = 8'h00;
    for (int i = 0; i < m; i += WRB) begin
      w = 32'h0;
      for (int j = 0; j < WRB && i + j < m; j++) w[8*j +: 8] = prog[i+j];
      exp_wd.push_back(w);
      exp_sh.push_back(((m - i >= WRB) ? WRB : m - i) - 1);
    end
    for (int i = 0; i < m; i++) sum = sum + prog[i];
    exp_err = sum != prog[prog.size()-1];
    nwin = exp_wd.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cnt_clear", cnt, 0);
    idx = 0;
    cyc = 0;
    stall_left = stall_cyc;
    while (!done && cyc < 3000) begin
      check("rdy_we_excl", rdy & we, 0);
      if (we) begin
        if (exp_wd.size() == 0) check("extra_we", 1, 0);
        else begin
          check("wr_data", wd, exp_wd[0]);
          check("shift", sh, exp_sh[0]);
          check("sat_wr_data", wd2, exp_wd[0]);
          check("sat_shift", sh2, exp_sh[0]);
        end
      end
      if (we && stall_left > 0) begin
        wr_rdy = 1'b0;
        stall_left--;
      end else wr_rdy = $urandom_range(99) < rdy_pct;
      vld = idx < prog.size() && $urandom_range(99) < vld_pct;
      b = vld ? prog[idx] : 8'($urandom);
      last = vld ? (idx == prog.size() - 1) : 1'($urandom);
      start = $urandom_range(9) == 0;
      if (we && wr_rdy && exp_wd.size() > 0) begin
        void'(exp_wd.pop_front());
        void'(exp_sh.pop_front());
      end
      if (rdy && vld) idx++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    vld = 1'b0;
    last = 1'b0;
    check("timeout", cyc < 3000, 1);
    check("done", done, 1);
    check("sat_done", done2, 1);
    check("bytes_used", idx, prog.size());
    check("windows_left", exp_wd.size(), 0);
    check("word_count", cnt, nwin);
    check("sat_count", cnt2, (nwin > 3) ? 3 : nwin);
    check("rdy_in_done", rdy | rdy2, 0);
    check("wd_cleared", wd, 0);
`ifdef LOADER_CHECKSUM_EN
    check("chk_err", chk_err, exp_err);
    check("sat_chk_err", chk_err2, exp_err);
`else
    if (exp_err) check("unused_sum", 0, 0);
`endif
    @(negedge clk);
    check("done_hold", done, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_rdy", rdy, 0);
    check("rst_we", we, 0);
    check("rst_wd", wd, 0);
    check("rst_shift", sh, 0);
    check("rst_done", done, 0);
    check("rst_cnt", cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_rdy", rdy, 0);
    set_prog(64'h6D736100, 4);
    run_session(100, 100, 0);
    set_prog(64'h060504030201, 6);
    run_session(100, 100, 0);
    set_prog(64'h8877665544332211, 8);
    run_session(100, 100, 5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vld = 1'b1;
    b = 8'hAA;
    @(negedge clk);
    b = 8'hBB;
    @(negedge clk);
    vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_rdy", rdy, 0);
    check("mid_rst_we", we, 0);
    check("mid_rst_wd", wd, 0);
    check("mid_rst_shift", sh, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_cnt", cnt, 0);
    @(negedge clk);
    check("mid_rst_no_we", we, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", rdy, 0);
    set_prog(64'h6D736100, 4);
    run_session(100, 100, 0);
    prog.delete();
    for (int i = 0; i < 20; i++) prog.push_back(8'(i + 1));
    run_session(100, 100, 0);
    set_prog(64'h60302010, 4);
    run_session(100, 100, 0);
    set_prog(64'h61302010, 4);
    run_session(100, 100, 0);
    set_prog(64'h0A04030201, 5);
    run_session(100, 100, 0);
    for (int s = 0; s < 30; s++) begin
      int n;
      n = $urandom_range(13, 1);
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back(8'($urandom));
      run_session($urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(3));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
